uart_tx_sched: RTL and testbench



---
 rtl/uart_tx_sched.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// ---------------------------------------------------------------------------
// uart_tx_sched
//   Byte scheduler in front of the UART transmitter. Shares the TX channel
//   between a framed sensor-word stream and a single-byte message port, and
//   paces each byte on the UART tx_empty handshake.
//
//   Frame: HEAD_BYTE, WORDS x 4 payload bytes (MSB first), [checksum], TAIL_BYTE.
//
//   Optional feature macro: UART_SCHED_CHECKSUM_EN
//     defined   -> an XOR checksum of all payload bytes is sent before TAIL.
//     undefined -> TAIL directly follows the last payload byte.
//
// Ports
//   clock_in    in   scheduler clock (same as UART txclk)
//   reset       in   synchronous, active-high
//   frm_req     in   frame source has a word available
//   frm_word    in   current frame word
//   frm_ack     out  pulse: frm_word captured
//   msg_req     in   message byte pending
//   msg_byte    in   pending message byte
//   msg_ack     out  pulse: msg_byte captured
//   tx_empty    in   UART transmitter idle
//   ld_tx_data  out  one-cycle load strobe to UART
//   tx_data     out  byte to UART
//   tx_enable   out  UART TX enable (high in every cycle after reset)
//   sync        out  pulse when a frame HEAD is loaded
//   busy        out  state is not IDLE
// ---------------------------------------------------------------------------
module uart_tx_sched #(
    parameter logic [7:0] HEAD_BYTE = 8'hAA,
    parameter logic [7:0] TAIL_BYTE = 8'h55,
    parameter int         WORDS     = 4
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic        frm_req,
    input  logic [31:0] frm_word,
    output logic        frm_ack,
    input  logic        msg_req,
    input  logic [7:0]  msg_byte,
    output logic        msg_ack,
    input  logic        tx_empty,
    output logic        ld_tx_data,
    output logic [7:0]  tx_data,
    output logic        tx_enable,
    output logic        sync,
    output logic        busy
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HEAD,
        ST_WORD,
`ifdef UART_SCHED_CHECKSUM_EN
        ST_CHK,
`endif
        ST_TAIL,
        ST_MSG,
        ST_WAIT_BUSY,
        ST_WAIT_EMPTY
    } state_t;

    localparam logic       LG_FRM    = 1'b0;
    localparam logic       LG_MSG    = 1'b1;
    localparam logic [7:0] LAST_WORD = 8'(WORDS - 1);
`ifdef UART_SCHED_CHECKSUM_EN
    localparam state_t     AFTER_PAY = ST_CHK;
`else
    localparam state_t     AFTER_PAY = ST_TAIL;
`endif

    state_t      r_state;
    state_t      r_next;        // byte state to resume after WAIT_EMPTY
    logic        r_last_grant;
    logic [1:0]  r_byte_idx;
    logic [7:0]  r_word_idx;
    logic [31:0] r_word;
    logic [1:0]  r_wb_cnt;      // WAIT_BUSY timeout counter
    logic        r_ld;
    logic [7:0]  r_tx_data;
    logic        r_frm_ack;
    logic        r_msg_ack;
    logic        r_sync;
    logic        r_tx_enable;
`ifdef UART_SCHED_CHECKSUM_EN
    logic [7:0]  r_chk;
`endif

    logic        w_grant_frm;
    logic        w_grant_msg;
    logic [7:0]  w_pay_byte;

    // Round robin: on a tie the source not served last wins.
    assign w_grant_frm = frm_req && (!msg_req || r_last_grant == LG_MSG);
    assign w_grant_msg = msg_req && !w_grant_frm;

    // Byte 0 comes straight from the source, since the word is captured in
    // the same cycle it is loaded; later bytes come from the captured copy.
    always_comb begin
        w_pay_byte = r_word[7:0];
        case (r_byte_idx)
            2'd0:    w_pay_byte = frm_word[31:24];
            2'd1:    w_pay_byte = r_word[23:16];
            2'd2:    w_pay_byte = r_word[15:8];
            default: w_pay_byte = r_word[7:0];
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_next       <= ST_IDLE;
            r_last_grant <= LG_MSG;
            r_byte_idx   <= 2'd0;
            r_word_idx   <= 8'd0;
            r_word       <= 32'h0;
            r_wb_cnt     <= 2'd0;
            r_ld         <= 1'b0;
            r_tx_data    <= 8'h00;
            r_frm_ack    <= 1'b0;
            r_msg_ack    <= 1'b0;
            r_sync       <= 1'b0;
            r_tx_enable  <= 1'b0;
`ifdef UART_SCHED_CHECKSUM_EN
            r_chk        <= 8'h00;
`endif
        end else begin
            r_ld        <= 1'b0;
            r_frm_ack   <= 1'b0;
            r_msg_ack   <= 1'b0;
            r_sync      <= 1'b0;
            r_tx_enable <= 1'b1;
            r_wb_cnt    <= 2'd0;
            case (r_state)
                ST_IDLE: begin
                    r_byte_idx <= 2'd0;
                    r_word_idx <= 8'd0;
                    // Grant and load in one step so the first byte appears
                    // the cycle after the request is seen.
                    if (w_grant_frm) begin
                        r_last_grant <= LG_FRM;
                        if (tx_empty) begin
                            r_tx_data <= HEAD_BYTE;
                            r_ld      <= 1'b1;
                            r_sync    <= 1'b1;
                            r_next    <= ST_WORD;
                            r_state   <= ST_WAIT_BUSY;
`ifdef UART_SCHED_CHECKSUM_EN
                            r_chk     <= 8'h00;
`endif
                        end else begin
                            r_state <= ST_HEAD;
                        end
                    end else if (w_grant_msg) begin
                        r_last_grant <= LG_MSG;
                        if (tx_empty) begin
                            r_tx_data <= msg_byte;
                            r_ld      <= 1'b1;
                            r_msg_ack <= 1'b1;
                            r_next    <= ST_IDLE;
                            r_state   <= ST_WAIT_BUSY;
                        end else begin
                            r_state <= ST_MSG;
                        end
                    end
                end
                ST_HEAD: if (tx_empty) begin
                    r_tx_data <= HEAD_BYTE;
                    r_ld      <= 1'b1;
                    r_sync    <= 1'b1;
                    r_next    <= ST_WORD;
                    r_state   <= ST_WAIT_BUSY;
`ifdef UART_SCHED_CHECKSUM_EN
                    r_chk     <= 8'h00;
`endif
                end
                ST_WORD: begin
                    // First byte of a word waits for the source (underflow
                    // holds here without truncating the frame).
                    if (tx_empty && (r_byte_idx != 2'd0 || frm_req)) begin
                        if (r_byte_idx == 2'd0) begin
                            r_word    <= frm_word;
                            r_frm_ack <= 1'b1;
                        end
                        r_tx_data  <= w_pay_byte;
                        r_ld       <= 1'b1;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        r_state    <= ST_WAIT_BUSY;
`ifdef UART_SCHED_CHECKSUM_EN
                        r_chk      <= r_chk ^ w_pay_byte;
`endif
                        if (r_byte_idx == 2'd3) begin
                            r_word_idx <= r_word_idx + 8'd1;
                            r_next     <= (r_word_idx == LAST_WORD) ? AFTER_PAY : ST_WORD;
                        end else begin
                            r_next <= ST_WORD;
                        end
                    end
                end
`ifdef UART_SCHED_CHECKSUM_EN
                ST_CHK: if (tx_empty) begin
                    r_tx_data <= r_chk;
                    r_ld      <= 1'b1;
                    r_next    <= ST_TAIL;
                    r_state   <= ST_WAIT_BUSY;
                end
`endif
                ST_TAIL: if (tx_empty) begin
                    r_tx_data <= TAIL_BYTE;
                    r_ld      <= 1'b1;
                    r_next    <= ST_IDLE;
                    r_state   <= ST_WAIT_BUSY;
                end
                ST_MSG: if (tx_empty && msg_req) begin
                    r_tx_data <= msg_byte;
                    r_ld      <= 1'b1;
                    r_msg_ack <= 1'b1;
                    r_next    <= ST_IDLE;
                    r_state   <= ST_WAIT_BUSY;
                end
                // Give up waiting for the UART to go busy after 4 cycles so a
                // missed handshake cannot stall the scheduler.
                ST_WAIT_BUSY: begin
                    if (!tx_empty || r_wb_cnt == 2'd3)
                        r_state <= ST_WAIT_EMPTY;
                    else
                        r_wb_cnt <= r_wb_cnt + 2'd1;
                end
                ST_WAIT_EMPTY: if (tx_empty) r_state <= r_next;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ld_tx_data = r_ld;
    assign tx_data    = r_tx_data;
    assign frm_ack    = r_frm_ack;
    assign msg_ack    = r_msg_ack;
    assign sync       = r_sync;
    assign tx_enable  = r_tx_enable;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;
    localparam int WORDS = 2;

    logic        clock_in = 1'b0;
    logic        reset;
    logic        frm_req, msg_req, tx_empty;
    logic [31:0] frm_word;
    logic [7:0]  msg_byte, tx_data;
    logic        frm_ack, msg_ack, ld_tx_data, tx_enable, sync, busy;

    uart_tx_sched #(.HEAD_BYTE(8'hAA), .TAIL_BYTE(8'h55), .WORDS(WORDS)) u_dut (
        .clock_in(clock_in), .reset(reset),
        .frm_req(frm_req), .frm_word(frm_word), .frm_ack(frm_ack),
        .msg_req(msg_req), .msg_byte(msg_byte), .msg_ack(msg_ack),
        .tx_empty(tx_empty), .ld_tx_data(ld_tx_data), .tx_data(tx_data),
        .tx_enable(tx_enable), .sync(sync), .busy(busy)
    );

    always #5 clock_in = ~clock_in;

    // UART model: tx_empty drops the cycle after a load and stays low 10 cycles.
    int ucnt;
    always @(posedge clock_in) begin
        if (reset) begin
            tx_empty <= 1'b1;
            ucnt     <= 0;
        end else if (ld_tx_data) begin
            tx_empty <= 1'b0;
            ucnt     <= 10;
        end else if (ucnt != 0) begin
            ucnt <= ucnt - 1;
            if (ucnt == 1) tx_empty <= 1'b1;
        end
    end

    typedef struct packed {
        logic [7:0] data;
        logic       sync;
        logic       fack;
        logic       mack;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] fq[$];
    logic [7:0]  mq[$];
    logic        frm_gate = 1'b1;
    int checks = 0, failures = 0;
    int ld_cnt = 0, n_fack = 0, n_mack = 0, n_sync = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    // Monitor: scoreboard compare on every load, then advance the sources.
    // This is the only process driving the request-side inputs.
    always @(negedge clock_in) begin : mon
        exp_t e;
        if (reset !== 1'b1) begin
            if (ld_tx_data) begin
                ld_cnt++;
                if (sync)    n_sync++;
                if (frm_ack) n_fack++;
                if (msg_ack) n_mack++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL load_unexpected actual=%h/%b%b%b expected=none",
                             tx_data, sync, frm_ack, msg_ack);
                end else begin
                    e = exp_q.pop_front();
                    if ({tx_data, sync, frm_ack, msg_ack} !== e) begin
                        failures++;
                        $display("FAIL load_byte actual=%h s%b f%b m%b expected=%h s%b f%b m%b",
                                 tx_data, sync, frm_ack, msg_ack, e.data, e.sync, e.fack, e.mack);
                    end
                end
                if (frm_ack && fq.size() > 0) void'(fq.pop_front());
                if (msg_ack && mq.size() > 0) void'(mq.pop_front());
            end else if (sync || frm_ack || msg_ack) begin
                checks++;
                failures++;
                $display("FAIL stray_pulse actual=s%b f%b m%b expected=000", sync, frm_ack, msg_ack);
            end
        end
        frm_req  = frm_gate && (fq.size() > 0);
        frm_word = (fq.size() > 0) ? fq[0] : 32'h0;
        msg_req  = (mq.size() > 0);
        msg_byte = (mq.size() > 0) ? mq[0] : 8'h00;
    end

    task automatic exp_frame(input logic [31:0] w0, input logic [31:0] w1);
        logic [31:0] ws[2];
        logic [7:0]  b, x;
        ws[0] = w0; ws[1] = w1; x = 8'h00;
        exp_q.push_back({8'hAA, 1'b1, 1'b0, 1'b0});
        for (int w = 0; w < 2; w++)
            for (int k = 0; k < 4; k++) begin
                b = ws[w][31-8*k -: 8];
                x = x ^ b;
                exp_q.push_back({b, 1'b0, (k == 0), 1'b0});
            end
`ifdef UART_SCHED_CHECKSUM_EN
        exp_q.push_back({x, 1'b0, 1'b0, 1'b0});
`endif
        exp_q.push_back({8'h55, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic src_frame(input logic [31:0] w0, input logic [31:0] w1);
        exp_frame(w0, w1);
        fq.push_back(w0);
        fq.push_back(w1);
    endtask

    task automatic wait_ld(input int n, input string name);
        int t = 0;
        while (ld_cnt < n && t < 2000) begin
            @(negedge clock_in);
            t++;
        end
        checks++;
        if (ld_cnt < n) begin
            failures++;
            $display("FAIL %s_timeout actual=%0d loads expected=%0d", name, ld_cnt, n);
        end
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (!(exp_q.size() == 0 && busy === 1'b0 && tx_empty === 1'b1) && t < 4000) begin
            @(negedge clock_in);
            t++;
        end
        checks++;
        if (t >= 4000) begin
            failures++;
            $display("FAIL %s_drain actual=%0d pending expected=0", name, exp_q.size());
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ld"},    ld_tx_data, 0);
        chk({tag, "_data"},  tx_data,    8'h00);
        chk({tag, "_fack"},  frm_ack,    0);
        chk({tag, "_mack"},  msg_ack,    0);
        chk({tag, "_sync"},  sync,       0);
        chk({tag, "_busy"},  busy,       0);
        chk({tag, "_txen"},  tx_enable,  0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete(); fq.delete(); mq.delete();
        repeat (2) @(negedge clock_in);
        reset = 1'b0;
    endtask

    initial begin
        int base_f, base_m, base_s, l0, f0;
        reset = 1'b1;
        repeat (3) @(negedge clock_in);
        chk_reset_vals("rst");
        reset = 1'b0;
        @(negedge clock_in);
        chk("txen_after_rst", tx_enable, 1);
        chk("idle_not_busy", busy, 0);

        // Single frame, no contention.
        base_f = n_fack; base_s = n_sync; base_m = n_mack;
        src_frame(32'h12345678, 32'h11223344);
        drain("frame1");
        chk("frame1_facks", n_fack - base_f, 2);
        chk("frame1_syncs", n_sync - base_s, 1);
        chk("frame1_macks", n_mack - base_m, 0);

        // Both requesting from reset: frame, msg, frame, msg.
        do_reset();
        exp_frame(32'hA0B1C2D3, 32'hE4F50617);
        exp_q.push_back({8'hC3, 1'b0, 1'b0, 1'b1});
        exp_frame(32'h0F1E2D3C, 32'h4B5A6978);
        exp_q.push_back({8'h5A, 1'b0, 1'b0, 1'b1});
        fq.push_back(32'hA0B1C2D3); fq.push_back(32'hE4F50617);
        fq.push_back(32'h0F1E2D3C); fq.push_back(32'h4B5A6978);
        mq.push_back(8'hC3); mq.push_back(8'h5A);
        drain("rr");

        // Message arrives mid-frame: sent only after TAIL.
        base_m = n_mack;
        l0 = ld_cnt;
        src_frame(32'hDEADBEEF, 32'h01020304);
        exp_q.push_back({8'hC3, 1'b0, 1'b0, 1'b1});
        wait_ld(l0 + 2, "midmsg");
        mq.push_back(8'hC3);
        drain("midmsg");
        chk("midmsg_macks", n_mack - base_m, 1);

        // Source underflow between words.
        base_f = n_fack;
        l0 = ld_cnt;
        src_frame(32'hCAFEF00D, 32'h89ABCDEF);
        wait_ld(l0 + 2, "uflow_w0");
        frm_gate = 1'b0;
        wait_ld(l0 + 5, "uflow_w0b");
        l0 = ld_cnt; f0 = n_fack;
        repeat (50) @(negedge clock_in);
        chk("gap_no_load", ld_cnt - l0, 0);
        chk("gap_no_ack",  n_fack - f0, 0);
        chk("gap_busy",    busy, 1);
        frm_gate = 1'b1;
        drain("uflow");
        chk("uflow_facks", n_fack - base_f, 2);

        // Reset during WORD, then a fresh frame starting with HEAD.
        l0 = ld_cnt;
        src_frame(32'h77665544, 32'h33221100);
        wait_ld(l0 + 3, "midrst");
        repeat (2) @(negedge clock_in);
        reset = 1'b1;
        exp_q.delete(); fq.delete(); mq.delete();
        @(negedge clock_in);
        chk_reset_vals("midrst");
        reset = 1'b0;
        base_s = n_sync;
        src_frame(32'h5EC0FFEE, 32'h600DD00D);
        drain("restart");
        chk("restart_syncs", n_sync - base_s, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
